// File: rtl/frame_buf_arb.sv
// Circular frame-buffer arbiter: serialises one writer and one reader onto a
// single-port-at-a-time memory, with fair tie-breaking and a read-return timeout.
module frame_buf_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int BUF_SIZE   = 5,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    input  logic                  rd_req,
    output logic                  rd_ack,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_err,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic                  mem_wr_rdy,
    input  logic                  mem_rd_rdy,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_data_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR      = 2'd1;
    localparam logic [1:0] S_RD      = 2'd2;
    localparam logic [1:0] S_RD_WAIT = 2'd3;

    localparam int TW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);
    localparam logic [ADDR_WIDTH:0]   BUF_CNT  = (ADDR_WIDTH+1)'(BUF_SIZE);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(BUF_SIZE - 1);
    localparam logic [TW-1:0]         TO_LAST  = TW'(RD_TIMEOUT - 1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0]         timer;
    logic                  last_grant;  // 1 = read was granted last
    logic                  wr_elig, rd_elig;

    assign wr_elig = wr_req & ~full & mem_wr_rdy;
    // The reader still holds rd_req while its ack/err pulse is visible, so that
    // cycle must not be taken as a fresh request.
    assign rd_elig = rd_req & ~empty & mem_rd_rdy & ~rd_ack & ~rd_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            timer       <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            last_grant  <= 1'b1;
            wr_ack      <= 1'b0;
            rd_ack      <= 1'b0;
            rd_err      <= 1'b0;
            rd_data     <= '0;
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_rd_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            wr_ack    <= 1'b0;
            rd_ack    <= 1'b0;
            rd_err    <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_elig && (!rd_elig || last_grant)) begin
                        state       <= S_WR;
                        mem_wr_en   <= 1'b1;
                        wr_ack      <= 1'b1;
                        mem_wr_addr <= wr_ptr;
                        mem_wr_data <= wr_data;
                    end else if (rd_elig) begin
                        state       <= S_RD;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= rd_ptr;
                    end
                end
                S_WR: begin
                    wr_ptr     <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
                    count      <= count + 1'b1;
                    full       <= (count + 1'b1) == BUF_CNT;
                    empty      <= 1'b0;
                    last_grant <= 1'b0;
                    state      <= S_IDLE;
                end
                S_RD: begin
                    timer <= '0;
                    state <= S_RD_WAIT;
                end
                default: begin
                    if (mem_rd_data_valid) begin
                        rd_data    <= mem_rd_data;
                        rd_ack     <= 1'b1;
                        rd_ptr     <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
                        count      <= count - 1'b1;
                        full       <= 1'b0;
                        empty      <= count == (ADDR_WIDTH+1)'(1);
                        last_grant <= 1'b1;
                        state      <= S_IDLE;
                    end else if (timer == TO_LAST) begin
                        rd_err <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frame_buf_arb.sv
// Randomised bench for frame_buf_arb: transaction-level queue model plus a
// latency-programmable memory responder.
module tb_frame_buf_arb;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam int BS = 5;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_req = 1'b0, rd_req = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack, rd_ack, rd_err;
    logic [DW-1:0] rd_data;
    logic          mem_wr_en, mem_rd_en;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_wr_rdy = 1'b1, mem_rd_rdy = 1'b1;
    logic [DW-1:0] mem_rd_data = '0;
    logic          mem_rd_data_valid = 1'b0;
    logic          full, empty;
    logic [AW:0]   count;

    frame_buf_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUF_SIZE(BS), .RD_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .rd_err(rd_err),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_rdy(mem_wr_rdy), .mem_rd_rdy(mem_rd_rdy),
        .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid),
        .full(full), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    // Memory: writes land on the strobe; reads answer rd_lat cycles after the
    // strobe cycle (rd_lat = 0 means never).
    logic [DW-1:0] mem [0:7];
    int            rd_lat = 1;
    int            pend = 0;
    int            valid_seen = 0;
    logic [AW-1:0] lat_addr = '0;

    always @(posedge clk) if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;

    always @(negedge clk) begin
        mem_rd_data_valid = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                mem_rd_data_valid = 1'b1;
                mem_rd_data = mem[lat_addr];
                valid_seen = valid_seen + 1;
            end
        end
        if (mem_rd_en && rd_lat > 0) begin
            pend = rd_lat;
            lat_addr = mem_rd_addr;
        end
    end

    // Reference model
    logic [DW-1:0] q[$];
    int wa = 0, ra = 0;
    int prev_op = 0;  // op that finished on this very edge: 0 none, 1 write, 2 read
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(q.size()));
        chk({tag, "_full"},  32'(full),  32'(q.size() == BS));
        chk({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        if (n > 0) begin
            prev_op = 0;
            chk_status("idle");
        end
    endtask

    task automatic model_reset();
        q.delete();
        wa = 0;
        ra = 0;
        prev_op = 0;
    endtask

    task automatic do_write(input logic [DW-1:0] d);
        int extra, cyc;
        bit got;
        extra = (prev_op == 1) ? 1 : 0;
        cyc = 0;
        got = 0;
        wr_data = d;
        wr_req = 1'b1;
        if (q.size() == BS) begin
            repeat (6) begin
                @(negedge clk);
                chk("full_stall_en", 32'(mem_wr_en), 0);
                chk("full_stall_ack", 32'(wr_ack), 0);
            end
            wr_req = 1'b0;
            prev_op = 0;
            chk_status("full_stall");
            return;
        end
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (wr_ack) got = 1;
        end
        chk("wr_ack_seen", 32'(got), 1);
        if (got) begin
            chk("wr_lat", 32'(cyc), 32'(1 + extra));
            chk("wr_en", 32'(mem_wr_en), 1);
            chk("wr_excl", 32'(mem_rd_en), 0);
            chk("wr_addr", 32'(mem_wr_addr), 32'(wa));
            chk("wr_data", mem_wr_data, d);
            q.push_back(d);
            wa = (wa + 1) % BS;
        end
        wr_req = 1'b0;
        prev_op = 1;
    endtask

    task automatic do_read(input int lat);
        int extra, cyc;
        bit done, saw_en, ok;
        extra = (prev_op != 0) ? 1 : 0;
        cyc = 0;
        done = 0;
        saw_en = 0;
        ok = (lat >= 1 && lat <= TO);
        rd_lat = lat;
        rd_req = 1'b1;
        if (q.size() == 0) begin
            repeat (6) begin
                @(negedge clk);
                chk("empty_stall_en", 32'(mem_rd_en), 0);
                chk("empty_stall_ack", 32'(rd_ack | rd_err), 0);
            end
            rd_req = 1'b0;
            prev_op = 0;
            return;
        end
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_rd_en) begin
                saw_en = 1;
                chk("rd_addr", 32'(mem_rd_addr), 32'(ra));
                chk("rd_excl", 32'(mem_wr_en), 0);
            end
            if (rd_ack || rd_err) done = 1;
        end
        chk("rd_strobe_seen", 32'(saw_en), 1);
        chk("rd_done_seen", 32'(done), 1);
        if (ok) begin
            chk("rd_ack", 32'(rd_ack), 1);
            chk("rd_no_err", 32'(rd_err), 0);
            chk("rd_lat", 32'(cyc), 32'(2 + lat + extra));
            if (rd_ack) begin
                chk("rd_data", rd_data, q[0]);
                void'(q.pop_front());
                ra = (ra + 1) % BS;
            end
        end else begin
            chk("rd_err", 32'(rd_err), 1);
            chk("rd_err_no_ack", 32'(rd_ack), 0);
            chk("rd_err_lat", 32'(cyc), 32'(2 + TO + extra));
        end
        rd_req = 1'b0;
        prev_op = 2;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_ack"}, 32'(wr_ack), 0);
        chk({tag, "_rd_ack"}, 32'(rd_ack), 0);
        chk({tag, "_rd_err"}, 32'(rd_err), 0);
        chk({tag, "_wr_en"},  32'(mem_wr_en), 0);
        chk({tag, "_rd_en"},  32'(mem_rd_en), 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_count"},  32'(count), 0);
        chk({tag, "_empty"},  32'(empty), 1);
        chk({tag, "_full"},   32'(full), 0);
    endtask

    initial begin
        int r, s, l, snap, waited;
        bit exp_w, got;

        // Reset state
        @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        model_reset();

        // Fill with 1..5 back-to-back, then a stalled 6th write
        for (int i = 1; i <= BS; i++) do_write(32'(i));
        do_write(32'd6);
        idle(1);

        // Drain in order with 1-cycle memory latency
        for (int i = 0; i < BS; i++) do_read(1);
        idle(1);
        do_read(2);  // empty: must stall

        // Timeout boundaries and retry at the same address
        do_write(32'hA5A5_0001);
        idle(1);
        do_read(0);
        idle(1);
        do_read(16);
        idle(1);
        do_read(TO);
        idle(1);

        // Memory write not ready holds the grant off
        mem_wr_rdy = 1'b0;
        wr_data = 32'hBEEF;
        wr_req = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("wr_rdy_stall", 32'(mem_wr_en), 0);
        end
        mem_wr_rdy = 1'b1;
        do_write(32'hBEEF);
        idle(1);

        // Reset while waiting for read data; the late return must be dropped
        rd_lat = 6;
        rd_req = 1'b1;
        waited = 0;
        while (!mem_rd_en && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_mid_strobe", 32'(mem_rd_en), 1);
        repeat (2) @(negedge clk);
        snap = valid_seen;
        reset = 1'b1;
        rd_req = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (8) begin
            @(negedge clk);
            chk("rst_late_no_ack", 32'(rd_ack), 0);
        end
        chk("rst_late_valid_sent", 32'(valid_seen > snap), 1);
        chk_status("rst_after");

        // Tie break: count=2 with last grant a read -> W,R,W,R,...
        do_write(32'h11);
        do_write(32'h22);
        do_write(32'h33);
        idle(1);
        do_read(1);
        idle(2);
        rd_lat = 1;
        wr_data = 32'h100;
        wr_req = 1'b1;
        rd_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_w = (k % 2 == 0);
            got = 0;
            waited = 0;
            while (!got && waited < 30) begin
                @(negedge clk);
                waited++;
                chk("tie_excl", 32'(mem_wr_en & mem_rd_en), 0);
                if (wr_ack || rd_ack) got = 1;
            end
            chk("tie_grant_seen", 32'(got), 1);
            chk("tie_order", 32'(wr_ack), 32'(exp_w));
            if (wr_ack) begin
                chk("tie_wr_addr", 32'(mem_wr_addr), 32'(wa));
                q.push_back(wr_data);
                wa = (wa + 1) % BS;
                wr_data = wr_data + 1;
            end else if (rd_ack) begin
                chk("tie_rd_data", rd_data, q[0]);
                void'(q.pop_front());
                ra = (ra + 1) % BS;
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        idle(2);

        // Random mix: wraps, stalls, timeouts around the boundary
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
                do_write($urandom);
            end else begin
                s = $urandom_range(0, 9);
                if (s == 0) l = 0;
                else if (s == 1) l = $urandom_range(14, 17);
                else l = $urandom_range(1, 5);
                do_read(l);
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
